// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the EX-stage forwarding / load-use hazard slice:
// operand-mux select encodings, the zero register and tracking-record widths.
package fwd_hazard_unit_pkg;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_MEMWB   = 2'b10;

    localparam int REG_ZERO = 0;

    // IDEX carries reg_write and mem_read; older stages only need reg_write.
    localparam int IDEX_CTRL_W = 2;
    localparam int DST_CTRL_W  = 1;

    // The younger producer (EX/MEM) shadows the older one (MEM/WB).
    function automatic logic [1:0] fwd_select(input logic exmem_hit, input logic memwb_hit);
        if (exmem_hit) return FWD_EXMEM;
        if (memwb_hit) return FWD_MEMWB;
        return FWD_REGFILE;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_pipe_track_stage.sv
// One pipeline tracking register: a valid bit plus an opaque payload, with
// hold (freeze), bubble (load valid=0) and normal load behaviour.
module pipe_track_stage #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_hold,
    input  logic         i_bubble,
    input  logic         i_load_valid,
    input  logic [W-1:0] i_load_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value and the pipe shifts cleanly.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            // NOTE: the payload is reset too; it is only a few flops and keeps
            // X out of the compare logic even though valid already gates it.
            o_data  <= '0;
        end else if (i_hold) begin
            o_valid <= o_valid;
            o_data  <= o_data;
        end else if (i_bubble) begin
            o_valid <= 1'b0;
            o_data  <= o_data;
        end else begin
            o_valid <= i_load_valid;
            o_data  <= i_load_data;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Tracks destinations of the ID/EX, EX/MEM and MEM/WB stages, drives the EX
// operand forwarding selects and requests a one-cycle load-use stall.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [REG_ADDR_W-1:0] i_id_rs,
    input  logic [REG_ADDR_W-1:0] i_id_rt,
    input  logic                  i_id_rs_used,
    input  logic                  i_id_rt_used,
    input  logic [REG_ADDR_W-1:0] i_id_rd,
    input  logic                  i_id_reg_write,
    input  logic                  i_id_mem_read,
    input  logic                  i_flush,
    input  logic                  i_hold,
    output logic [1:0]            o_fwd_a,
    output logic [1:0]            o_fwd_b,
    output logic                  o_stall
);

    localparam int IDEX_W = 3 * REG_ADDR_W + IDEX_CTRL_W;
    localparam int DST_W  = REG_ADDR_W + DST_CTRL_W;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = REG_ADDR_W'(REG_ZERO);

    logic                  idex_valid, exmem_valid, memwb_valid;
    logic [IDEX_W-1:0]     idex_d, idex_q;
    logic [DST_W-1:0]      exmem_d, exmem_q, memwb_q;

    logic [REG_ADDR_W-1:0] idex_rs, idex_rt, idex_rd, exmem_rd, memwb_rd;
    logic                  idex_reg_write, idex_mem_read;
    logic                  exmem_reg_write, memwb_reg_write;
    logic                  load_hazard, idex_bubble;

    assign idex_d = {i_id_rs, i_id_rt, i_id_rd, i_id_reg_write, i_id_mem_read};
    assign {idex_rs, idex_rt, idex_rd, idex_reg_write, idex_mem_read} = idex_q;

    assign exmem_d = {idex_rd, idex_reg_write};
    assign {exmem_rd, exmem_reg_write} = exmem_q;
    assign {memwb_rd, memwb_reg_write} = memwb_q;

    pipe_track_stage #(.W(IDEX_W)) u_idex (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_hold       (i_hold),
        .i_bubble     (idex_bubble),
        .i_load_valid (1'b1),
        .i_load_data  (idex_d),
        .o_valid      (idex_valid),
        .o_data       (idex_q)
    );

    pipe_track_stage #(.W(DST_W)) u_exmem (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_hold       (i_hold),
        .i_bubble     (1'b0),
        .i_load_valid (idex_valid),
        .i_load_data  (exmem_d),
        .o_valid      (exmem_valid),
        .o_data       (exmem_q)
    );

    pipe_track_stage #(.W(DST_W)) u_memwb (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_hold       (i_hold),
        .i_bubble     (1'b0),
        .i_load_valid (exmem_valid),
        .i_load_data  (exmem_q),
        .o_valid      (memwb_valid),
        .o_data       (memwb_q)
    );

    function automatic logic producer_hit(
        input logic                  valid,
        input logic                  reg_write,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] src
    );
        return valid && reg_write && (rd != ZERO_REG) && (rd == src);
    endfunction

    // Forwarding looks only at tracked state, never at the ID inputs.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs (no latches).
        o_fwd_a = FWD_REGFILE;
        o_fwd_b = FWD_REGFILE;
        if (idex_valid) begin
            o_fwd_a = fwd_select(producer_hit(exmem_valid, exmem_reg_write, exmem_rd, idex_rs),
                                 producer_hit(memwb_valid, memwb_reg_write, memwb_rd, idex_rs));
            o_fwd_b = fwd_select(producer_hit(exmem_valid, exmem_reg_write, exmem_rd, idex_rt),
                                 producer_hit(memwb_valid, memwb_reg_write, memwb_rd, idex_rt));
        end
    end

    assign load_hazard = idex_valid && idex_mem_read && idex_reg_write && (idex_rd != ZERO_REG) &&
                         (((idex_rd == i_id_rs) && i_id_rs_used) ||
                          ((idex_rd == i_id_rt) && i_id_rt_used));

    // A frozen pipe cannot stall and a killed instruction must not stall.
    assign o_stall     = load_hazard && !i_hold && !i_flush;
    assign idex_bubble = i_flush || o_stall;

endmodule
